// File: rtl/avl_ram_port_arbiter.sv
// Round-robin arbiter sharing one Avalon-style slave port between NUM_MASTERS masters.
// Outstanding reads are tracked in an in-order ID FIFO so returning data reaches its issuer.
module avl_ram_port_arbiter #(
   parameter int NUM_MASTERS = 2,
   parameter int RSP_DEPTH   = 4,
   parameter int AW          = 32,
   parameter int DW          = 32
) (
   input  logic                        clk,
   input  logic                        rest,
   input  logic [NUM_MASTERS*AW-1:0]   m_address,
   input  logic [NUM_MASTERS*DW/8-1:0] m_byte_en,
   input  logic [NUM_MASTERS-1:0]      m_read,
   input  logic [NUM_MASTERS-1:0]      m_write,
   input  logic [NUM_MASTERS*DW-1:0]   m_write_data,
   output logic [NUM_MASTERS-1:0]      m_request_ready,
   output logic [DW-1:0]               m_read_data,
   output logic [NUM_MASTERS-1:0]      m_read_data_valid,
   output logic [AW-1:0]               s_address,
   output logic [DW/8-1:0]             s_byte_en,
   output logic                        s_read,
   output logic                        s_write,
   output logic [DW-1:0]               s_write_data,
   input  logic                        s_request_ready,
   input  logic [DW-1:0]               s_read_data,
   input  logic                        s_read_data_valid,
   output logic                        err_orphan
);

   localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam int BW = DW / 8;

   logic [IW-1:0]          rr_ptr_r;
   logic [IW-1:0]          fifo_r [RSP_DEPTH];
   logic [PW-1:0]          rd_ptr_r;
   logic [PW-1:0]          wr_ptr_r;
   logic [CW-1:0]          count_r;
   logic                   err_orphan_r;

   logic                   full_s;
   logic                   found_s;
   logic                   take_s;
   logic                   accept_s;
   logic                   push_s;
   logic                   pop_s;
   logic [NUM_MASTERS-1:0] eligible_s;
   logic [NUM_MASTERS-1:0] grant_s;
   logic [IW-1:0]          gidx_s;
   logic [IW-1:0]          rr_next_s;
   logic [IW:0]            sum_s;
   logic [IW:0]            cand_s;

   // A full FIFO blocks reads only; the registered count is used so a same-cycle pop never unblocks.
   assign full_s     = (count_r == CW'(RSP_DEPTH));
   assign eligible_s = m_write | (m_read & {NUM_MASTERS{~full_s}});

   // Round-robin search for the first eligible requester starting at rr_ptr_r
   always_comb begin
      grant_s = '0;
      gidx_s  = '0;
      found_s = 1'b0;
      take_s  = 1'b0;
      sum_s   = '0;
      cand_s  = '0;
      for (int k = 0; k < NUM_MASTERS; k++) begin
         sum_s   = {1'b0, rr_ptr_r} + (IW+1)'(k);
         cand_s  = (sum_s >= (IW+1)'(NUM_MASTERS)) ? (sum_s - (IW+1)'(NUM_MASTERS)) : sum_s;
         take_s  = ~found_s & eligible_s[cand_s[IW-1:0]];
         grant_s[cand_s[IW-1:0]] = grant_s[cand_s[IW-1:0]] | take_s;
         gidx_s  = take_s ? cand_s[IW-1:0] : gidx_s;
         found_s = found_s | take_s;
      end
   end

   // With no grant gidx_s stays 0, so the slave side then shows master 0's fields.
   assign s_address    = m_address[gidx_s*AW +: AW];
   assign s_byte_en    = m_byte_en[gidx_s*BW +: BW];
   assign s_write_data = m_write_data[gidx_s*DW +: DW];
   assign s_write      = found_s & m_write[gidx_s];
   assign s_read       = found_s & m_read[gidx_s] & ~m_write[gidx_s];

   assign m_request_ready = grant_s & {NUM_MASTERS{s_request_ready}};
   assign accept_s        = found_s & s_request_ready;
   assign push_s          = accept_s & ~m_write[gidx_s];
   assign pop_s           = s_read_data_valid & (count_r != '0);
   assign rr_next_s       = (gidx_s == IW'(NUM_MASTERS - 1)) ? '0 : (gidx_s + 1'b1);

   assign m_read_data       = s_read_data;
   assign m_read_data_valid = pop_s ? (NUM_MASTERS'(1) << fifo_r[rd_ptr_r]) : '0;
   assign err_orphan        = err_orphan_r;

   // Arbitration pointer, read-ID FIFO and sticky orphan flag
   always_ff @(posedge clk or negedge rest) begin
      if (!rest) begin
         rr_ptr_r     <= '0;
         rd_ptr_r     <= '0;
         wr_ptr_r     <= '0;
         count_r      <= '0;
         err_orphan_r <= 1'b0;
         for (int i = 0; i < RSP_DEPTH; i++) begin
            fifo_r[i] <= '0;
         end
      end else begin
         if (accept_s) begin
            rr_ptr_r <= rr_next_s;
         end
         if (push_s) begin
            fifo_r[wr_ptr_r] <= gidx_s;
            wr_ptr_r         <= wr_ptr_r + 1'b1;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + 1'b1;
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + 1'b1;
            2'b01:   count_r <= count_r - 1'b1;
            default: count_r <= count_r;
         endcase
         if (s_read_data_valid && (count_r == '0)) begin
            err_orphan_r <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_avl_ram_port_arbiter.sv
// Directed bench for avl_ram_port_arbiter: a queue-based reference model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_avl_ram_port_arbiter;

   localparam int NM = 2;
   localparam int RD = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int BW = DW / 8;

   logic              clk = 1'b0;
   logic              rest;
   logic [NM*AW-1:0]  m_address;
   logic [NM*BW-1:0]  m_byte_en;
   logic [NM-1:0]     m_read;
   logic [NM-1:0]     m_write;
   logic [NM*DW-1:0]  m_write_data;
   logic [NM-1:0]     m_request_ready;
   logic [DW-1:0]     m_read_data;
   logic [NM-1:0]     m_read_data_valid;
   logic [AW-1:0]     s_address;
   logic [BW-1:0]     s_byte_en;
   logic              s_read;
   logic              s_write;
   logic [DW-1:0]     s_write_data;
   logic              s_request_ready;
   logic [DW-1:0]     s_read_data;
   logic              s_read_data_valid;
   logic              err_orphan;

   int n_checks = 0;
   int n_pass   = 0;

   bit            auto_mode;
   logic          man_valid;
   logic [DW-1:0] man_data;
   logic [DW-1:0] mem [logic [AW-1:0]];

   int q[$];
   int rr;
   bit err;

   avl_ram_port_arbiter #(.NUM_MASTERS(NM), .RSP_DEPTH(RD), .AW(AW), .DW(DW)) dut (
      .clk(clk), .rest(rest),
      .m_address(m_address), .m_byte_en(m_byte_en), .m_read(m_read), .m_write(m_write),
      .m_write_data(m_write_data), .m_request_ready(m_request_ready),
      .m_read_data(m_read_data), .m_read_data_valid(m_read_data_valid),
      .s_address(s_address), .s_byte_en(s_byte_en), .s_read(s_read), .s_write(s_write),
      .s_write_data(s_write_data), .s_request_ready(s_request_ready),
      .s_read_data(s_read_data), .s_read_data_valid(s_read_data_valid),
      .err_orphan(err_orphan)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [DW-1:0] rdmem(input logic [AW-1:0] a);
      if (mem.exists(a)) return mem[a];
      return ~a;
   endfunction

   // 1-cycle RAM slave (auto_mode) or hand-driven returns
   always begin
      logic          cap_rd;
      logic [AW-1:0] cap_addr;
      logic [DW-1:0] tmp;
      @(negedge clk);
      cap_rd   = rest && s_read && s_request_ready;
      cap_addr = s_address;
      if (rest && s_write && s_request_ready) begin
         tmp = mem.exists(s_address) ? mem[s_address] : '0;
         for (int b = 0; b < BW; b++)
            if (s_byte_en[b]) tmp[b*8 +: 8] = s_write_data[b*8 +: 8];
         mem[s_address] = tmp;
      end
      @(posedge clk);
      #2;
      if (auto_mode) begin
         s_read_data_valid = cap_rd;
         s_read_data       = cap_rd ? rdmem(cap_addr) : '0;
      end else begin
         s_read_data_valid = man_valid;
         s_read_data       = man_data;
      end
   end

   // Reference model: compare current outputs, then advance the model state
   always @(negedge clk) begin
      int g;
      int sel;
      bit full;
      logic [NM-1:0] e_rdy;
      logic [NM-1:0] e_rdv;
      if (!rest) begin
         q.delete();
         rr  = 0;
         err = 0;
      end
      full = (q.size() == RD);
      g = -1;
      for (int k = 0; k < NM; k++) begin
         int i;
         i = (rr + k) % NM;
         if (g < 0 && (m_write[i] || (m_read[i] && !full))) g = i;
      end
      sel   = (g >= 0) ? g : 0;
      e_rdy = '0;
      if (g >= 0 && s_request_ready) e_rdy[g] = 1'b1;
      e_rdv = '0;
      if (s_read_data_valid && q.size() > 0) e_rdv[q[0]] = 1'b1;
      chk("m_request_ready", m_request_ready, e_rdy);
      chk("s_write", s_write, (g >= 0) && m_write[sel]);
      chk("s_read", s_read, (g >= 0) && m_read[sel] && !m_write[sel]);
      chk("s_address", s_address, m_address[sel*AW +: AW]);
      chk("s_byte_en", s_byte_en, m_byte_en[sel*BW +: BW]);
      chk("s_write_data", s_write_data, m_write_data[sel*DW +: DW]);
      chk("m_read_data_valid", m_read_data_valid, e_rdv);
      chk("m_read_data", m_read_data, s_read_data);
      chk("err_orphan", err_orphan, err);
      if (rest) begin
         if (s_read_data_valid) begin
            if (q.size() > 0) void'(q.pop_front());
            else err = 1;
         end
         if (g >= 0 && s_request_ready) begin
            rr = (g + 1) % NM;
            if (!m_write[g]) q.push_back(g);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic peek();
      #3;
   endtask

   task automatic set_m(input int i, input logic rd, input logic wr,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
      m_read[i]              = rd;
      m_write[i]             = wr;
      m_address[i*AW +: AW]  = a;
      m_write_data[i*DW +: DW] = d;
      m_byte_en[i*BW +: BW]  = '1;
   endtask

   initial begin
      int cnt0;
      int cnt1;
      rest = 1'b0;
      m_address = '0; m_byte_en = '0; m_read = '0; m_write = '0; m_write_data = '0;
      s_request_ready = 1'b1; s_read_data = '0; s_read_data_valid = 1'b0;
      auto_mode = 1'b1; man_valid = 1'b0; man_data = '0;
      cnt0 = 0; cnt1 = 0;
      tick(); tick();
      chk("reset_ready", m_request_ready, 2'b00);
      chk("reset_s_read", s_read, 1'b0);
      chk("reset_s_write", s_write, 1'b0);
      chk("reset_err", err_orphan, 1'b0);
      rest = 1'b1;

      // single master write then read on the 1-cycle RAM
      tick(); set_m(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
      peek(); chk("t1_wr_ready", m_request_ready, 2'b01);
      tick(); set_m(0, 1'b1, 1'b0, 32'h10, 32'h0);
      peek(); chk("t1_rd_ready", m_request_ready, 2'b01); chk("t1_s_read", s_read, 1'b1);
      tick(); m_read = '0; m_write = '0;
      peek(); chk("t1_rdv", m_read_data_valid, 2'b01); chk("t1_data", m_read_data, 32'hDEADBEEF);

      // round-robin from reset
      tick(); rest = 1'b0;
      tick(); rest = 1'b1;
      set_m(0, 1'b1, 1'b0, 32'h20, 32'h0); set_m(1, 1'b1, 1'b0, 32'h24, 32'h0);
      for (int k = 0; k < 8; k++) begin
         peek();
         chk("t2_grant", m_request_ready, (k % 2) ? 2'b10 : 2'b01);
         if (k > 0) chk("t2_rdv", m_read_data_valid, ((k - 1) % 2) ? 2'b10 : 2'b01);
         cnt0 += int'(m_request_ready[0]);
         cnt1 += int'(m_request_ready[1]);
         tick();
      end
      m_read = '0;
      peek(); chk("t2_last_rdv", m_read_data_valid, 2'b10);
      chk("t2_share0", cnt0, 4); chk("t2_share1", cnt1, 4);

      // backpressure with rr_ptr = 1
      tick(); set_m(0, 1'b1, 1'b0, 32'h30, 32'h0);
      peek(); chk("t3_pre", m_request_ready, 2'b01);
      tick(); s_request_ready = 1'b0; set_m(1, 1'b1, 1'b0, 32'h34, 32'h0);
      for (int k = 0; k < 3; k++) begin
         peek();
         chk("t3_stall_ready", m_request_ready, 2'b00);
         chk("t3_stall_addr", s_address, 32'h34);
         chk("t3_stall_read", s_read, 1'b1);
         tick();
      end
      s_request_ready = 1'b1;
      peek(); chk("t3_release", m_request_ready, 2'b10);
      tick(); m_read[1] = 1'b0;
      peek(); chk("t3_next", m_request_ready, 2'b01);
      tick(); m_read = '0;
      tick(); tick();

      // FIFO full with delayed returns (rr_ptr = 1)
      auto_mode = 1'b0;
      set_m(0, 1'b1, 1'b0, 32'h40, 32'h0); set_m(1, 1'b1, 1'b0, 32'h44, 32'h0);
      for (int k = 0; k < 4; k++) begin
         peek(); chk("t4_fill", m_request_ready, (k % 2) ? 2'b01 : 2'b10);
         tick();
      end
      peek(); chk("t4_full_ready", m_request_ready, 2'b00); chk("t4_full_read", s_read, 1'b0);
      tick(); set_m(0, 1'b0, 1'b1, 32'h48, 32'h5555AAAA);
      peek(); chk("t4_write_ready", m_request_ready, 2'b01); chk("t4_write", s_write, 1'b1);
      tick(); m_write[0] = 1'b0; m_read[0] = 1'b0; man_valid = 1'b1; man_data = 32'hCAFE0001;
      peek(); chk("t4_pop_ready", m_request_ready, 2'b00);
      chk("t4_pop_rdv", m_read_data_valid, 2'b10); chk("t4_pop_data", m_read_data, 32'hCAFE0001);
      tick(); man_valid = 1'b0;
      peek(); chk("t4_unblock", m_request_ready, 2'b10);
      tick(); m_read = '0; man_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         peek(); chk("t4_drain", m_read_data_valid, (k % 2) ? 2'b10 : 2'b01);
         tick();
      end

      // orphan return
      peek(); chk("t5_rdv", m_read_data_valid, 2'b00); chk("t5_err_now", err_orphan, 1'b0);
      tick(); man_valid = 1'b0;
      peek(); chk("t5_err_set", err_orphan, 1'b1);
      tick();
      peek(); chk("t5_err_sticky", err_orphan, 1'b1);

      // async reset mid-burst
      tick(); set_m(0, 1'b0, 1'b1, 32'h50, 32'h0);
      peek(); chk("t6_wr", m_request_ready, 2'b01);
      tick(); set_m(0, 1'b1, 1'b0, 32'h60, 32'h0); set_m(1, 1'b1, 1'b0, 32'h64, 32'h0);
      peek(); chk("t6_g1", m_request_ready, 2'b10);
      tick();
      peek(); chk("t6_g0", m_request_ready, 2'b01);
      tick(); man_valid = 1'b1;
      #2;
      chk("t6_pre_ready", m_request_ready, 2'b10); chk("t6_pre_rdv", m_read_data_valid, 2'b10);
      rest = 1'b0;
      #1;
      chk("t6_async_err", err_orphan, 1'b0);
      chk("t6_async_rdv", m_read_data_valid, 2'b00);
      chk("t6_async_ready", m_request_ready, 2'b01);
      tick(); m_read = '0; rest = 1'b1;
      peek(); chk("t6_late_rdv", m_read_data_valid, 2'b00); chk("t6_late_err0", err_orphan, 1'b0);
      tick(); man_valid = 1'b0; m_read = 2'b11;
      peek(); chk("t6_late_err1", err_orphan, 1'b1); chk("t6_first_grant", m_request_ready, 2'b01);
      tick(); m_read = '0;
      tick(); tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/avl_ram_port_arbiter.md
Name: avl_ram_port_arbiter

Overview:
- Shares one Avalon-style slave port (e.g. one port of the dual-port RAM) between NUM_MASTERS requesting masters.
- Round-robin arbitration, one granted transfer per cycle.
- Tracks outstanding reads in an in-order ID FIFO so each returning read_data_valid is routed to the master that issued it.
- Sits between core-side masters (fetch, LSU, debug) and a RAM or peripheral slave port.

Parameters:
NUM_MASTERS, 2, number of requesting masters (2..8)
RSP_DEPTH, 4, max outstanding reads; power of 2, >=2
AW, 32, address width
DW, 32, data width; byte_en width = DW/8

Ports:
clk  in  1  clock
rest  in  1  asynchronous active-low reset
m_address  in  NUM_MASTERS*AW  master addresses, master i at [i*AW +: AW]
m_byte_en  in  NUM_MASTERS*DW/8  master byte enables
m_read  in  NUM_MASTERS  read request per master
m_write  in  NUM_MASTERS  write request per master
m_write_data  in  NUM_MASTERS*DW  master write data
m_request_ready  out  NUM_MASTERS  request accepted this cycle, per master
m_read_data  out  DW  read data, broadcast to all masters
m_read_data_valid  out  NUM_MASTERS  read data valid, one-hot to the owning master
s_address  out  AW  slave address
s_byte_en  out  DW/8  slave byte enable
s_read  out  1  slave read
s_write  out  1  slave write
s_write_data  out  DW  slave write data
s_request_ready  in  1  slave accepts request
s_read_data  in  DW  slave read data
s_read_data_valid  in  1  slave read data valid; returns are in order
err_orphan  out  1  sticky: read data returned with no read outstanding

Behaviour:
- Reset (rest=0, async):
  - rr_ptr=0, FIFO empty (count 0, rd/wr pointers 0), err_orphan=0.
  - Combinational outputs follow from this state: with no requests, all m_request_ready=0 and s_read=s_write=0.
- Request from master i: req[i] = m_read[i] | m_write[i].
  - Masters hold their request stable until m_request_ready[i].
  - Read and write both high on one master is illegal; write takes priority.
- Eligibility: a master whose request is a read (write low) is ineligible while FIFO count == RSP_DEPTH.
  - Eligibility depends only on registered count; a same-cycle pop does not unblock.
  - Writes are always eligible.
- Grant is combinational, one-hot:
  - First eligible requester searching i = rr_ptr, rr_ptr+1, ... modulo NUM_MASTERS.
  - No eligible requester: grant=0.
- Slave drive:
  - s_* carry the granted master's address, byte_en and write_data.
  - s_read/s_write = granted master's read/write.
  - No grant: s_read=s_write=0; address, byte_en and data are don't-care, driven from master 0.
- Handshake: m_request_ready[i] = grant[i] & s_request_ready. A transfer completes when it is high.
- On a completed transfer by master g (registered):
  - rr_ptr <= (g+1) mod NUM_MASTERS.
  - If it was a read, push g into the FIFO.
- If s_request_ready is low, rr_ptr is unchanged and the grant persists next cycle as long as requests persist, so there is no starvation.
- Read return:
  - m_read_data = s_read_data, combinational.
  - If s_read_data_valid and FIFO non-empty: m_read_data_valid[head]=1 (combinational) and pop.
  - If s_read_data_valid and FIFO empty: no m_read_data_valid; err_orphan <= 1 (sticky until reset).
- Simultaneous push and pop: count unchanged and both pointers advance; legal at count==RSP_DEPTH only when the push is a write (i.e. no push).
- Pointers wrap modulo RSP_DEPTH.
- Latency: the arbiter adds zero cycles in both directions. With the 1-cycle RAM, data arrives the cycle after acceptance.
- Reset mid-operation: all outstanding reads are forgotten; late slave returns after reset set err_orphan.

Test Plan:
1. Single master: NUM_MASTERS=2, master 0 writes 0xDEADBEEF to 0x10, then reads 0x10 on a 1-cycle-latency RAM model -> m_request_ready[0]=1 each request cycle; next cycle after the read, m_read_data_valid=2'b01 with data 0xDEADBEEF.
2. Round-robin: masters 0 and 1 each issue continuous reads from reset -> grants alternate 0,1,0,1; m_read_data_valid alternates 01,10 one cycle behind; each master gets 50% over 8 cycles.
3. Backpressure: s_request_ready=0 for 3 cycles with both requesting and rr_ptr=1 -> master 1 granted, s_address stable on master 1's address for all 3 cycles; on release, master 1 completes, then master 0 is granted.
4. FIFO full: slave model delays returns; both masters issue 4 reads -> 5th read gets no grant and count stays 4; a master-0 write in the same cycle is still granted; after one s_read_data_valid, the read is granted the following cycle.
5. Orphan: s_read_data_valid=1 with FIFO empty -> m_read_data_valid=0; err_orphan=1 from the next cycle, persisting until rest=0.
6. Async reset: assert rest low mid-burst, between clock edges -> rr_ptr, FIFO and err_orphan clear immediately without a clock edge; the first request after release is granted to master 0.
